dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  MEM-stage sequencer for a variable-latency data memory with a req/ack handshake.
//  Decodes the load/store in EX/MEM, drives the memory request and byte enables, and stalls PC, IF/ID, ID/EX and EX/MEM until ack.
//  Produces extended load data for mem_wb.mem_data_in and a bubble to force mem_wb.RegWrite_in=0 while busy.
// PARAMETERS
//  TIMEOUT  15  REQ cycles without ack before abort (used only with DMEM_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-high
//  mem_read_i    in   1   EX/MEM MemRead
//  mem_write_i   in   1   EX/MEM MemWrite
//  funct3_i      in   3   load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr_i        in   32  byte address from ALU
//  wdata_i       in   32  store data (rs2)
//  dmem_req_o    out  1   request, held until ack
//  dmem_we_o     out  1   1 = write
//  dmem_addr_o   out  32  word address {addr_i[31:2],2'b00}
//  dmem_be_o     out  4   byte enables
//  dmem_wdata_o  out  32  lane-replicated store data
//  dmem_ack_i    in   1   memory ack; rdata valid in the same cycle
//  dmem_rdata_i  in   32  read word
//  stall_o       out  1   freeze upstream pipeline registers
//  wb_bubble_o   out  1   zero RegWrite into MEM/WB
//  load_data_o   out  32  extended load result
//  misalign_o    out  1   1-cycle pulse: misaligned access or bad funct3
//  timeout_o     out  1   1-cycle pulse: access aborted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Reset mid-REQ drops req at once; the access is abandoned.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//  IDLE, acc = mem_read_i|mem_write_i:
//  - acc=1 and legal: stall_o=1, wb_bubble_o=1; register addr/be/wdata/we; go to REQ.
//  - acc=1 and illegal: misalign_o=1, no request, stall_o=0, store suppressed, load_data_o=0; stay in IDLE.
//  - acc=0: all outputs idle; stay in IDLE.
//  Illegal: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 011/110/111.
//  REQ: dmem_req_o=1; stall_o=1; wb_bubble_o=1; addr/be/wdata/we held stable.
//  - On ack: capture extended rdata into load_data_o; go to DONE.
//  DONE: stall_o=0 and wb_bubble_o=0 for exactly 1 cycle; the pipeline advances and MEM/WB samples load_data_o.
//  - A request is never re-issued from DONE; next state is IDLE.
//  Minimum access = 3 cycles (2 stall cycles); each ack wait state adds 1 cycle.
//  Write priority: if read and write are both set, perform a write.
//  dmem_ack_i outside REQ is ignored.
//  Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<{addr[1],1'b0}; W = 4'b1111.
//  Store data: byte replicated x4, half replicated x2, word as-is.
//  Loads: select lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
//  load_data_o holds its value until the next completed load; stores leave it unchanged.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//  - REQ cycle counter ($clog2(TIMEOUT+1) bits), cleared on REQ entry.
//  - When the count reaches TIMEOUT with no ack: dmem_req_o=0, timeout_o=1 for 1 cycle, load_data_o=0, go to DONE.
//  - An ack arriving in the same cycle as the limit wins; no timeout is raised.
//  DMEM_TIMEOUT_EN undefined: REQ waits indefinitely; timeout_o tied 0; no counter logic.
// TESTING
//  1 LW 0x100, ack in 1st REQ cycle, rdata 0xDEADBEEF -> req 1 cycle, stall 2 cycles, load_data_o=0xDEADBEEF in DONE.
//  2 LB 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x00008011.
//  3 SH 0x102, wdata 0x1234ABCD -> we=1, be=4'b1100, dmem_wdata_o=0xABCDABCD, addr=0x100.
//  4 LW 0x101 -> misalign_o 1 cycle, req never asserted, stall_o=0.
//  5 ack delayed 5 cycles -> req high 6 cycles, addr stable; rst pulsed mid-REQ -> req/stall 0 immediately.
//  6 DMEM_TIMEOUT_EN, TIMEOUT=15, no ack -> req drops after 15 REQ cycles, timeout_o pulse, DONE, then IDLE.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage sequencer and the memory.
interface dmem_access_ctrl_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory (req/ack handshake).
// Stalls the upstream pipeline while an access is outstanding and returns
// extended load data. Optional abort-on-timeout: define DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_i,
  input  logic                       mem_write_i,
  input  logic [2:0]                 funct3_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  dmem_access_ctrl_if.master         dmem,
  output logic                       stall_o,
  output logic                       wb_bubble_o,
  output logic [31:0]                load_data_o,
  output logic                       misalign_o,
  output logic                       timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  state_t      state, state_d;
  logic        acc, illegal, start;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] addr_q, wdata_q, load_q, load_ext;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic        in_req;

  assign acc    = mem_read_i | mem_write_i;
  assign in_req = (state == REQ);

  // Size decode: legality, byte enables and lane-replicated store data
  always_comb begin
    illegal = 1'b0;
    be_d    = '0;
    wdata_d = wdata_i;
    case (funct3_i)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      3'b001, 3'b101: begin
        illegal = addr_i[0];
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wdata_i[15:0]}};
      end
      3'b010: begin
        illegal = (addr_i[1:0] != 2'b00);
        be_d    = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Load lane select and sign/zero extension of the returned word
  always_comb begin
    logic [31:0] byte_sh, half_sh;
    byte_sh = dmem.dmem_rdata_i >> {addr_q[1:0], 3'b000};
    half_sh = dmem.dmem_rdata_i >> {addr_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_ext = {24'h0, byte_sh[7:0]};
      3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_ext = {16'h0, half_sh[15:0]};
      default: load_ext = dmem.dmem_rdata_i;
    endcase
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] req_cnt;
  logic          at_limit, timeout_hit, timeout_q;

  // req_cnt counts REQ cycles already elapsed, so the limit is seen in the TIMEOUT-th REQ cycle
  assign at_limit = (req_cnt == CW'(TIMEOUT - 1));

  // REQ cycle counter, cleared whenever a new access starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         req_cnt <= '0;
    else if (start)  req_cnt <= '0;
    else if (in_req) req_cnt <= req_cnt + CW'(1);
  end

  // Abort pulse, visible during the DONE cycle that follows the abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_hit;
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Next-state and handshake/stall outputs; reset forces everything idle
  always_comb begin
    state_d     = state;
    start       = 1'b0;
    stall_o     = 1'b0;
    wb_bubble_o = 1'b0;
    misalign_o  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    if (!rst) begin
      case (state)
        IDLE: begin
          if (acc) begin
            if (illegal) begin
              misalign_o = 1'b1;
            end else begin
              start       = 1'b1;
              stall_o     = 1'b1;
              wb_bubble_o = 1'b1;
              state_d     = REQ;
            end
          end
        end
        REQ: begin
          stall_o     = 1'b1;
          wb_bubble_o = 1'b1;
          if (dmem.dmem_ack_i) begin
            state_d = DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (at_limit) begin
            timeout_hit = 1'b1;
            state_d     = DONE;
          end
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Access registers captured at start and held for the whole request; load result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      if (start) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        f3_q    <= funct3_i;
        we_q    <= mem_write_i;
      end
      if (in_req && dmem.dmem_ack_i && !we_q) load_q <= load_ext;
`ifdef DMEM_TIMEOUT_EN
      else if (timeout_hit) load_q <= '0;
`endif
    end
  end

  assign dmem.dmem_req_o   = in_req;
  assign dmem.dmem_we_o    = in_req & we_q;
  assign dmem.dmem_be_o    = in_req ? be_q : '0;
  assign dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata_o = wdata_q;
  // Illegal access reports zero load data without disturbing the held result
  assign load_data_o       = misalign_o ? '0 : load_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table plus multi-cycle sequences.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, wb_bubble_o, misalign_o, timeout_o;
  logic [31:0] load_data_o;

  int tests = 0;
  int failed = 0;

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .dmem        (bus.master),
    .stall_o     (stall_o),
    .wb_bubble_o (wb_bubble_o),
    .load_data_o (load_data_o),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          dly;
    logic        mis, we;
    logic [3:0]  be;
    logic [31:0] waddr, wout, ld;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    int reqc, addr_bad;
    reqc = 0;
    addr_bad = 0;
    @(negedge clk);
    mem_read_i = v.rd; mem_write_i = v.wr; funct3_i = v.f3;
    addr_i = v.addr; wdata_i = v.wdata;
    #1;
    if (v.mis) begin
      chk($sformatf("v%0d misalign", idx), {31'b0, misalign_o}, 32'd1);
      chk($sformatf("v%0d mis_stall", idx), {30'b0, stall_o, wb_bubble_o}, 32'd0);
      chk($sformatf("v%0d mis_ld", idx), load_data_o, 32'd0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("v%0d mis_noreq", idx), {30'b0, bus.dmem_req_o, stall_o}, 32'd0);
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      #1;
      chk($sformatf("v%0d mis_clear", idx), {31'b0, misalign_o}, 32'd0);
    end else begin
      chk($sformatf("v%0d start", idx), {29'b0, stall_o, wb_bubble_o, bus.dmem_req_o}, 32'd6);
      @(posedge clk);
      for (int i = 0; i <= v.dly; i++) begin
        @(negedge clk);
        if (bus.dmem_req_o) reqc++;
        if (bus.dmem_addr_o !== v.waddr || stall_o !== 1'b1) addr_bad++;
        if (i == 0) begin
          chk($sformatf("v%0d we", idx), {31'b0, bus.dmem_we_o}, {31'b0, v.we});
          chk($sformatf("v%0d be", idx), {28'b0, bus.dmem_be_o}, {28'b0, v.be});
          if (v.we) chk($sformatf("v%0d wdata", idx), bus.dmem_wdata_o, v.wout);
        end
        if (i == v.dly) begin
          bus.dmem_ack_i = 1'b1;
          bus.dmem_rdata_i = v.rdata;
        end
        @(posedge clk);
      end
      @(negedge clk);
      bus.dmem_ack_i = 1'b0;
      bus.dmem_rdata_i = 32'hA5A5A5A5;
      chk($sformatf("v%0d req_cycles", idx), reqc, v.dly + 1);
      chk($sformatf("v%0d addr_stable", idx), addr_bad, 0);
      chk($sformatf("v%0d done", idx), {29'b0, bus.dmem_req_o, stall_o, wb_bubble_o}, 32'd0);
      chk($sformatf("v%0d load", idx), load_data_o, v.ld);
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      @(posedge clk);
    end
  endtask

  initial begin
    int reqc, to_bad;
    bus.dmem_ack_i = 1'b0;
    bus.dmem_rdata_i = '0;

    //         rd    wr    f3      addr          wdata         rdata         dly mis   we    be       waddr         wout          ld
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0, 4'b1111, 32'h00000100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0,        32'h80112233, 0, 1'b0, 1'b0, 4'b1000, 32'h00000100, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0,        32'h80112233, 0, 1'b0, 1'b0, 4'b1000, 32'h00000100, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h00000102, 32'h0,        32'h80112233, 0, 1'b0, 1'b0, 4'b1100, 32'h00000100, 32'h0,        32'h00008011};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h00000100, 32'h0,        32'h80112233, 1, 1'b0, 1'b0, 4'b0011, 32'h00000100, 32'h0,        32'h00002233};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0,        32'h80112233, 0, 1'b0, 1'b0, 4'b1100, 32'h00000100, 32'h0,        32'hFFFF8011};
    vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h00000102, 32'h1234ABCD, 32'h0,        0, 1'b0, 1'b1, 4'b1100, 32'h00000100, 32'hABCDABCD, 32'hFFFF8011};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h00000201, 32'h000000A5, 32'h0,        0, 1'b0, 1'b1, 4'b0010, 32'h00000200, 32'hA5A5A5A5, 32'hFFFF8011};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h00000204, 32'hCAFEF00D, 32'h0,        3, 1'b0, 1'b1, 4'b1111, 32'h00000204, 32'hCAFEF00D, 32'hFFFF8011};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h00000101, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'b001, 32'h00000103, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h00000300, 32'h11223344, 32'h99999999, 0, 1'b0, 1'b1, 4'b1111, 32'h00000300, 32'h11223344, 32'hFFFF8011};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h00000102, 32'h0,        32'h7F55AA01, 5, 1'b0, 1'b0, 4'b0100, 32'h00000100, 32'h0,        32'h00000055};
    vecs[14] = '{1'b1, 1'b0, 3'b110, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {26'b0, bus.dmem_req_o, bus.dmem_we_o, stall_o, wb_bubble_o, misalign_o, timeout_o}, 32'd0);
    chk("reset_be", {28'b0, bus.dmem_be_o}, 32'd0);
    chk("reset_load", load_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stray ack while idle must be ignored
    @(negedge clk);
    bus.dmem_ack_i = 1'b1;
    bus.dmem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk); @(negedge clk);
    chk("stray_ack", {30'b0, bus.dmem_req_o, stall_o}, 32'd0);
    chk("stray_ack_load", load_data_o, 32'd0);
    bus.dmem_ack_i = 1'b0;

    for (int i = 0; i < 15; i++) apply(i, vecs[i]);

    // Long wait with no ack: abort after TIMEOUT cycles, or wait indefinitely
    @(negedge clk);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h00000400;
    @(posedge clk);
    reqc = 0;
    to_bad = 0;
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.dmem_req_o) break;
      reqc++;
      if (timeout_o) to_bad++;
    end
    chk("to_req_cycles", reqc, 15);
    chk("to_early_pulse", to_bad, 0);
    chk("to_pulse", {31'b0, timeout_o}, 32'd1);
    chk("to_done", {30'b0, stall_o, wb_bubble_o}, 32'd0);
    chk("to_load", load_data_o, 32'd0);
    mem_read_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("to_pulse_end", {29'b0, timeout_o, bus.dmem_req_o, stall_o}, 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.dmem_req_o) reqc++;
      if (timeout_o) to_bad++;
    end
    chk("wait_req_cycles", reqc, 20);
    chk("wait_no_timeout", to_bad, 0);
    bus.dmem_ack_i = 1'b1;
    bus.dmem_rdata_i = 32'h13579BDF;
    @(posedge clk); @(negedge clk);
    bus.dmem_ack_i = 1'b0;
    chk("wait_load", load_data_o, 32'h13579BDF);
    mem_read_i = 1'b0;
    @(posedge clk);
`endif

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h00000500;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_req_before", {31'b0, bus.dmem_req_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_req_after", {29'b0, bus.dmem_req_o, stall_o, wb_bubble_o}, 32'd0);
    mem_read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_recovered", {30'b0, bus.dmem_req_o, stall_o}, 32'd0);
    chk("rst_load", load_data_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
